// File: rtl/z3_pkg.sv
// Shared types and constants for the Zorro III slave-cycle engine.
// The optional access timeout is enabled by defining Z3_TIMEOUT_BERR_EN.
package z3_pkg;

  localparam int unsigned REGION_W    = 24;
  localparam int unsigned CNT_W       = 8;
  localparam logic [7:0]  Z3_CFG_BASE = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    END,
    ERR
  } z3_state_t;

  // Only user/supervisor data and program spaces are decoded; CPU and unused spaces are not.
  function automatic logic validspace(input logic [1:0] fc);
    return fc[1] ^ fc[0];
  endfunction

endpackage

// File: rtl/z3_region_decode.sv
// Address window decode within the 16 MB slot; the lowest-index region wins on overlap.
module z3_region_decode
  import z3_pkg::*;
#(
  parameter int unsigned                        NUM_REGIONS = 5,
  parameter logic [NUM_REGIONS*REGION_W-1:0]    REGION_BASE = '0,
  parameter logic [NUM_REGIONS*REGION_W-1:0]    REGION_MASK = '0
) (
  input  logic [REGION_W-1:0]    addr_i,
  output logic [NUM_REGIONS-1:0] sel_c_o,
  output logic                   hit_c_o
);

  logic found;

  always_comb begin
    sel_c_o = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
      if (!found && ((addr_i & REGION_MASK[i*REGION_W +: REGION_W]) ==
                     REGION_BASE[i*REGION_W +: REGION_W])) begin
        sel_c_o[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign hit_c_o = found;

endmodule

// File: rtl/z3_slave_engine.sv
// Zorro III slave-cycle engine: region/autoconfig decode, back-end req/ack handshake, DTACK.
// Define Z3_TIMEOUT_BERR_EN to terminate stalled DATA phases with BERR after TIMEOUT_CYCLES.
module z3_slave_engine
  import z3_pkg::*;
#(
  parameter int unsigned                     NUM_REGIONS    = 5,
  parameter logic [NUM_REGIONS*REGION_W-1:0] REGION_BASE    = '0,
  parameter logic [NUM_REGIONS*REGION_W-1:0] REGION_MASK    = '0,
  parameter int unsigned                     TIMEOUT_CYCLES = 255
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   FCS,
  input  logic [31:0]            A,
  input  logic [2:0]             FC,
  input  logic                   READ,
  input  logic [3:0]             DS_n,
  input  logic [7:0]             BASE_ADDR,
  input  logic                   CONFIGURED,
  input  logic                   CFG_EN,
  output logic                   cfg_sel,
  output logic [NUM_REGIONS-1:0] region_sel,
  output logic [NUM_REGIONS-1:0] region_req,
  input  logic [NUM_REGIONS-1:0] region_ack,
  input  logic                   cfg_ack,
  output logic [REGION_W-1:0]    cycle_addr,
  output logic                   DTACK,
  output logic                   SLAVE,
  output logic                   BERR,
  output logic                   busy
);

  z3_state_t              state_q, state_d;
  logic [NUM_REGIONS-1:0] sel_q, sel_d, req_q, req_d, dec_sel;
  logic [REGION_W-1:0]    addr_q, addr_d;
  logic                   cfg_q, cfg_d, dtack_q, dtack_d, slave_q, slave_d, busy_q, busy_d;
  logic                   dec_hit, slot_match, cfg_match, accept, sel_ack;
  logic                   unused_fc;

  z3_region_decode #(
    .NUM_REGIONS (NUM_REGIONS),
    .REGION_BASE (REGION_BASE),
    .REGION_MASK (REGION_MASK)
  ) u_decode (
    .addr_i  (A[REGION_W-1:0]),
    .sel_c_o (dec_sel),
    .hit_c_o (dec_hit)
  );

  assign slot_match = (A[31:24] == BASE_ADDR) && CONFIGURED;
  assign cfg_match  = (A[31:24] == Z3_CFG_BASE) && CFG_EN;
  // A slot hit outside every region is not ours to answer.
  assign accept     = FCS && validspace(FC[1:0]) && (cfg_match || (slot_match && dec_hit));
  assign sel_ack    = cfg_q ? cfg_ack : |(region_ack & sel_q);
  assign unused_fc  = FC[2];

`ifdef Z3_TIMEOUT_BERR_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             berr_q, berr_d;
`else
  logic             unused_timeout;
  assign unused_timeout = ^(CNT_W'(TIMEOUT_CYCLES));
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    req_d   = req_q;
    cfg_d   = cfg_q;
    addr_d  = addr_q;
    dtack_d = dtack_q;
    slave_d = slave_q;
`ifdef Z3_TIMEOUT_BERR_EN
    berr_d  = berr_q;
    cnt_d   = '0;
`endif
    // FCS low aborts from any state; the back-end sees req fall and drops its ack.
    if (!FCS) begin
      state_d = IDLE;
      sel_d   = '0;
      req_d   = '0;
      cfg_d   = 1'b0;
      dtack_d = 1'b0;
      slave_d = 1'b0;
`ifdef Z3_TIMEOUT_BERR_EN
      berr_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_d = START;
            addr_d  = A[REGION_W-1:0];
            cfg_d   = cfg_match;
            sel_d   = cfg_match ? '0 : dec_sel;
            slave_d = 1'b1;
          end
        end
        START: begin
          if (READ || (DS_n != 4'hF)) begin
            state_d = DATA;
            req_d   = sel_q;
          end
        end
        DATA: begin
          if (sel_ack) begin
            state_d = END;
            req_d   = '0;
            dtack_d = 1'b1;
          end
`ifdef Z3_TIMEOUT_BERR_EN
          else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
            state_d = ERR;
            req_d   = '0;
            berr_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`endif
        end
        default: ;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      sel_q   <= '0;
      req_q   <= '0;
      cfg_q   <= 1'b0;
      addr_q  <= '0;
      dtack_q <= 1'b0;
      slave_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      req_q   <= req_d;
      cfg_q   <= cfg_d;
      addr_q  <= addr_d;
      dtack_q <= dtack_d;
      slave_q <= slave_d;
      busy_q  <= busy_d;
    end
  end

`ifdef Z3_TIMEOUT_BERR_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q  <= '0;
      berr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      berr_q <= berr_d;
    end
  end

  assign BERR = berr_q;
`else
  assign BERR = 1'b0;
`endif

  assign cfg_sel    = cfg_q;
  assign region_sel = sel_q;
  assign region_req = req_q;
  assign cycle_addr = addr_q;
  assign DTACK      = dtack_q;
  assign SLAVE      = slave_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_z3_slave_engine.sv
// Self-checking bench for z3_slave_engine: decode vector table with a scoreboard plus handshake corner cases.
module tb_z3_slave_engine;

  localparam int unsigned NR = 5;
  localparam int unsigned TO = 8;
  // Regions r4..r0; r2 sits inside r3 so the overlap resolves to r2.
  localparam logic [NR*24-1:0] RB = {24'h600000, 24'h400000, 24'h480000, 24'h800000, 24'h000000};
  localparam logic [NR*24-1:0] RM = {24'hFF0000, 24'hF00000, 24'hFF0000, 24'hF80000, 24'hF00000};

  logic          CLK, RESET, FCS, READ, CONFIGURED, CFG_EN, cfg_ack;
  logic [31:0]   A;
  logic [2:0]    FC;
  logic [3:0]    DS_n;
  logic [7:0]    BASE_ADDR;
  logic          cfg_sel, DTACK, SLAVE, BERR, busy;
  logic [NR-1:0] region_sel, region_req, region_ack;
  logic [23:0]   cycle_addr;

  z3_slave_engine #(
    .NUM_REGIONS    (NR),
    .REGION_BASE    (RB),
    .REGION_MASK    (RM),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .FCS        (FCS),
    .A          (A),
    .FC         (FC),
    .READ       (READ),
    .DS_n       (DS_n),
    .BASE_ADDR  (BASE_ADDR),
    .CONFIGURED (CONFIGURED),
    .CFG_EN     (CFG_EN),
    .cfg_sel    (cfg_sel),
    .region_sel (region_sel),
    .region_req (region_req),
    .region_ack (region_ack),
    .cfg_ack    (cfg_ack),
    .cycle_addr (cycle_addr),
    .DTACK      (DTACK),
    .SLAVE      (SLAVE),
    .BERR       (BERR),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  fc;
    logic [31:0] a;
    logic        rd;
    logic [3:0]  ds_n;
    logic        conf;
    logic        cen;
    int unsigned dly;
    logic        acc;
    logic [4:0]  sel;
    logic        cfg;
  } vec_t;

  typedef struct {
    logic        acc;
    logic [4:0]  sel;
    logic        cfg;
    logic [23:0] addr;
    int unsigned dly;
  } exp_t;

  vec_t vecs[12];
  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   stalls;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_dtack"}, 32'(DTACK), 32'd0);
    check({tag, "_slave"}, 32'(SLAVE), 32'd0);
    check({tag, "_berr"},  32'(BERR),  32'd0);
    check({tag, "_busy"},  32'(busy),  32'd0);
    check({tag, "_sel"},   32'(region_sel), 32'd0);
    check({tag, "_req"},   32'(region_req), 32'd0);
    check({tag, "_cfg"},   32'(cfg_sel), 32'd0);
  endtask

  // Drive one table cycle; the expectation is queued at FCS rise and retired once the IDLE edge has acted.
  task automatic apply(input int idx, input vec_t v);
    exp_t  e;
    string t;
    t = $sformatf("v%0d", idx);
    CONFIGURED = v.conf; CFG_EN = v.cen; FC = v.fc; A = v.a; READ = v.rd; DS_n = v.ds_n;
    FCS = 1'b1;
    sbq.push_back('{v.acc, v.sel, v.cfg, v.a[23:0], v.dly});
    tick();
    e = sbq.pop_front();
    check({t, "_slave"}, 32'(SLAVE), 32'(e.acc));
    check({t, "_busy"},  32'(busy),  32'(e.acc));
    check({t, "_sel"},   32'(region_sel), 32'(e.sel));
    check({t, "_cfg"},   32'(cfg_sel), 32'(e.cfg));
    if (e.acc) begin
      check({t, "_addr"},      32'(cycle_addr), 32'(e.addr));
      check({t, "_req_start"}, 32'(region_req), 32'd0);
      tick();
      check({t, "_req"}, 32'(region_req), 32'(e.sel));
      repeat (e.dly) tick();
      check({t, "_dtack_early"}, 32'(DTACK), 32'd0);
      if (e.cfg) cfg_ack = 1'b1;
      else region_ack = e.sel;
      tick();
      check({t, "_dtack"},   32'(DTACK), 32'd1);
      check({t, "_req_end"}, 32'(region_req), 32'd0);
      for (int i = 0; i < 10 && !DTACK; i++) tick();
      tick(); tick();
      check({t, "_dtack_hold"}, 32'(DTACK), 32'd1);
      check({t, "_slave_hold"}, 32'(SLAVE), 32'd1);
    end else begin
      repeat (3) tick();
      check({t, "_stay_idle"}, 32'(busy), 32'd0);
      check({t, "_no_slave"},  32'(SLAVE), 32'd0);
    end
    FCS = 1'b0; region_ack = '0; cfg_ack = 1'b0;
    tick();
    check_idle({t, "_end"});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          fc      a             rd    ds_n  conf  cen   dly acc   sel       cfg
    vecs[0]  = '{3'b001, 32'h4080_0004, 1'b1, 4'hF, 1'b1, 1'b0, 2, 1'b1, 5'b00010, 1'b0};
    vecs[1]  = '{3'b101, 32'h4000_1234, 1'b0, 4'h0, 1'b1, 1'b0, 0, 1'b1, 5'b00001, 1'b0};
    vecs[2]  = '{3'b010, 32'h4048_0010, 1'b1, 4'hF, 1'b1, 1'b0, 1, 1'b1, 5'b00100, 1'b0};
    vecs[3]  = '{3'b110, 32'h4040_0000, 1'b1, 4'hF, 1'b1, 1'b0, 0, 1'b1, 5'b01000, 1'b0};
    vecs[4]  = '{3'b001, 32'h4060_0000, 1'b0, 4'hE, 1'b1, 1'b0, 3, 1'b1, 5'b10000, 1'b0};
    vecs[5]  = '{3'b001, 32'hFF00_0000, 1'b0, 4'h7, 1'b0, 1'b1, 1, 1'b1, 5'b00000, 1'b1};
    vecs[6]  = '{3'b111, 32'h4080_0004, 1'b1, 4'hF, 1'b1, 1'b0, 0, 1'b0, 5'b00000, 1'b0};
    vecs[7]  = '{3'b001, 32'h4180_0004, 1'b1, 4'hF, 1'b1, 1'b0, 0, 1'b0, 5'b00000, 1'b0};
    vecs[8]  = '{3'b001, 32'h4070_0000, 1'b1, 4'hF, 1'b1, 1'b0, 0, 1'b0, 5'b00000, 1'b0};
    vecs[9]  = '{3'b001, 32'h4080_0004, 1'b1, 4'hF, 1'b0, 1'b0, 0, 1'b0, 5'b00000, 1'b0};
    vecs[10] = '{3'b001, 32'hFF00_0000, 1'b1, 4'hF, 1'b0, 1'b0, 0, 1'b0, 5'b00000, 1'b0};
    vecs[11] = '{3'b000, 32'h4080_0004, 1'b1, 4'hF, 1'b1, 1'b0, 0, 1'b0, 5'b00000, 1'b0};

    CLK = 1'b0; RESET = 1'b1; FCS = 1'b0; A = '0; FC = '0; READ = 1'b0; DS_n = 4'hF;
    BASE_ADDR = 8'h40; CONFIGURED = 1'b0; CFG_EN = 1'b0; region_ack = '0; cfg_ack = 1'b0;
    tick(); tick();
    check_idle("reset");
    check("reset_addr", 32'(cycle_addr), 32'd0);
    RESET = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) apply(i, vecs[i]);

    // Acks seen in IDLE/START are ignored; START waits for READ or a data strobe.
    CONFIGURED = 1'b1; CFG_EN = 1'b0; FC = 3'b001; A = 32'h4080_0004;
    READ = 1'b0; DS_n = 4'hF; region_ack = 5'b00010; FCS = 1'b1;
    tick(); tick(); tick();
    check("start_hold_busy", 32'(busy), 32'd1);
    check("start_hold_req",  32'(region_req), 32'd0);
    check("start_ack_ign",   32'(DTACK), 32'd0);
    DS_n = 4'h0;
    tick();
    check("start_data_req", 32'(region_req), 32'(5'b00010));
    tick();
    check("start_dtack", 32'(DTACK), 32'd1);
    FCS = 1'b0; region_ack = '0; DS_n = 4'hF;
    tick();
    check_idle("start_idle");

    // Acks from unselected regions and cfg_ack are ignored; END does not re-decode.
    READ = 1'b1; A = 32'h4080_0004; FCS = 1'b1;
    tick(); tick();
    region_ack = 5'b11101; cfg_ack = 1'b1;
    repeat (3) tick();
    check("nsel_dtack", 32'(DTACK), 32'd0);
    check("nsel_req",   32'(region_req), 32'(5'b00010));
    region_ack = 5'b00010; cfg_ack = 1'b0;
    tick();
    check("nsel_dtack_ok", 32'(DTACK), 32'd1);
    A = 32'h4040_0000;
    tick(); tick();
    check("end_keep_sel",   32'(region_sel), 32'(5'b00010));
    check("end_keep_dtack", 32'(DTACK), 32'd1);
    FCS = 1'b0; region_ack = '0;
    tick();
    check_idle("nsel_idle");

    // Abort from DATA, then a normal cycle.
    A = 32'h4080_0004; READ = 1'b1; FCS = 1'b1;
    tick(); tick(); tick();
    FCS = 1'b0;
    tick();
    check_idle("abort");
    apply(12, vecs[0]);

    // Synchronous reset in END wins over FCS.
    A = 32'h4080_0004; READ = 1'b1; FCS = 1'b1;
    tick(); tick();
    region_ack = 5'b00010;
    tick();
    check("rst_pre_dtack", 32'(DTACK), 32'd1);
    RESET = 1'b1;
    tick();
    check_idle("rst_mid");
    check("rst_mid_addr", 32'(cycle_addr), 32'd0);
    FCS = 1'b0; region_ack = '0; RESET = 1'b0;
    tick();

`ifdef Z3_TIMEOUT_BERR_EN
    A = 32'h4080_0004; READ = 1'b1; FCS = 1'b1;
    tick(); tick();
    repeat (TO) tick();
    check("to_pre_berr", 32'(BERR), 32'd0);
    check("to_pre_busy", 32'(busy), 32'd1);
    tick();
    check("to_berr",  32'(BERR), 32'd1);
    check("to_dtack", 32'(DTACK), 32'd0);
    check("to_req",   32'(region_req), 32'd0);
    region_ack = 5'b00010;
    tick(); tick();
    check("to_berr_hold", 32'(BERR), 32'd1);
    check("to_no_dtack",  32'(DTACK), 32'd0);
    FCS = 1'b0; region_ack = '0;
    tick();
    check_idle("to_idle");
    FCS = 1'b1;
    tick(); tick();
    repeat (TO) tick();
    region_ack = 5'b00010;
    tick();
    check("to_ack_wins_dtack", 32'(DTACK), 32'd1);
    check("to_ack_wins_berr",  32'(BERR), 32'd0);
    FCS = 1'b0; region_ack = '0;
    tick();
    check_idle("to_ack_idle");
`else
    A = 32'h4080_0004; READ = 1'b1; FCS = 1'b1;
    tick(); tick();
    stalls = 0;
    repeat (1000) begin
      tick();
      if (!busy || BERR || DTACK) stalls++;
    end
    check("nto_wait", 32'(stalls), 32'd0);
    FCS = 1'b0;
    tick();
    check_idle("nto_idle");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/z3_slave_engine.md
Name: z3_slave_engine

Overview:
Parametrised Zorro III slave-cycle engine replacing the fixed four-state slave FSM and hard-coded region decode in the A4092 top level. It samples buffered FCS and the address, then decodes up to NUM_REGIONS address windows inside the board's 16 MB slot, plus an autoconfig window. It runs a per-region request/acknowledge handshake toward back-end access units (ROM, SCSI, INTREG, IDREG, SPI, ...) and generates DTACK. An optional access timeout terminates the cycle with a bus error.

Parameters:
NUM_REGIONS, 5, number of decoded back-end regions; 1..8.
REGION_BASE, {5{24'h0}}, packed NUM_REGIONS x 24-bit window base offsets within the 16 MB slot.
REGION_MASK, {5{24'h0}}, packed NUM_REGIONS x 24-bit compare masks; a region hits when (A[23:0] & MASK) == BASE.
TIMEOUT_CYCLES, 255, CLK cycles in DATA before timeout; 1..255.

Ports:
CLK  in  1  board clock (25 MHz)
RESET  in  1  synchronous, active-high reset
FCS  in  1  buffered Zorro FCS, active-high (high = address latched)
A  in  32  Zorro address bus
FC  in  3  function codes
READ  in  1  Zorro READ
DS_n  in  4  Zorro data strobes, active-low
BASE_ADDR  in  8  assigned board base, compared against A[31:24]
CONFIGURED  in  1  board configured
CFG_EN  in  1  autoconfig window permitted (unconfigured, not shut up, CFGIN_n low)
cfg_sel  out  1  current cycle targets the autoconfig window
region_sel  out  NUM_REGIONS  one-hot region select, valid from START until IDLE
region_req  out  NUM_REGIONS  one-hot access request to the back-end
region_ack  in  NUM_REGIONS  back-end completion, level, per region
cfg_ack  in  1  autoconfig completion
cycle_addr  out  24  A[23:0] captured in IDLE
DTACK  out  1  active-high; the top level tri-states DTACK_n from it
SLAVE  out  1  active-high; the top level drives SLAVE_n from it
BERR  out  1  active-high bus error request
busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE; all outputs 0; cycle_addr=0; timeout counter=0.
- validspace = FC[1]^FC[0].
- Slot match: A[31:24]==BASE_ADDR and CONFIGURED.
- Config match: A[31:24]==8'hFF and CFG_EN.
- Region decode: lowest index wins on overlap. A slot match that hits no region is ignored and the FSM stays in IDLE.
- IDLE:
  - Condition: FCS=1, validspace, and (config match or slot match with a region hit).
  - Action: capture cycle_addr, cfg_sel, region_sel; go to START.
  - SLAVE asserts in the same transition, so it is registered with 1-cycle latency.
- START:
  - FCS=0 -> IDLE.
  - READ=1 or DS_n!=4'hF -> DATA; region_req (or the internal config request) asserts on entry.
- DATA:
  - Selected ack=1 -> END; region_req drops on END entry.
  - Counter increments each DATA cycle. Timeout handling is described under Optional Feature.
- END: DTACK=1 from the first END cycle; held until FCS=0.
- FCS=0 in any state -> IDLE on the next edge; DTACK, SLAVE, BERR, region_req, region_sel and cfg_sel all clear. This is an abort: the back-end must drop its ack when req drops.
- An ack arriving in START or IDLE is ignored.
- An ack on a non-selected region is ignored.
- Back-to-back cycles: FCS must be seen low for at least one CLK before a new cycle is accepted. The engine never re-arms from END directly.
- Minimum latency, FCS rise to DTACK with a 1-cycle ack: 4 CLK (IDLE, START, DATA, END).

Optional Feature:
Z3_TIMEOUT_BERR_EN.
- Defined:
  - Counter reaching TIMEOUT_CYCLES in DATA -> state ERR.
  - ERR: drop req; BERR=1 and DTACK=0; hold until FCS=0, then IDLE.
  - An ack and the timeout in the same cycle: the ack wins.
- Undefined:
  - No counter and no ERR state.
  - BERR tied 0; DATA waits indefinitely.

Decomposition:
- Package z3_pkg:
  - state enum: IDLE, START, DATA, END, ERR.
  - REGION_W=24 and the Z3_CFG_BASE=8'hFF constant.
  - validspace function.
- Sub-module z3_region_decode (combinational): compare + priority one-hot, parametrised by NUM_REGIONS/BASE/MASK.

Test Plan:
- BASE_ADDR=8'h40, CONFIGURED=1, A=32'h4080_0004, READ=1, FC=3'b001 -> region_sel=5'b00010 (region1 base 24'h800000, mask 24'hF80000); req at cycle 3; ack 2 cycles later; DTACK held until FCS low; then all outputs 0.
- CONFIGURED=0, CFG_EN=1, A=32'hFF00_0000, write with DS_n=4'h7 -> cfg_sel=1; cfg_ack -> DTACK; no region_sel bit set.
- FC=3'b111 (CPU space) or A[31:24]=8'h41 -> engine stays IDLE; SLAVE stays 0.
- FCS dropped while in DATA with no ack -> next edge: IDLE, req=0, DTACK=0; a following cycle decodes normally.
- Z3_TIMEOUT_BERR_EN, TIMEOUT_CYCLES=8, no ack -> BERR=1 on the 9th DATA-state edge, DTACK never asserts; without the macro, busy stays 1 for 1000 cycles.
- RESET=1 asserted mid-END -> next edge: all outputs 0 and state IDLE, regardless of FCS.
